// File: rtl/cordic_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : cordic_result_collector
// Purpose  : Gain-compensates and saturates CORDIC result beats, then buffers
//            them in a small FIFO with drop and saturation bookkeeping.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_result_collector #(
    parameter int NUM_DATA       = 3,
    parameter int FUNC_WIDTH     = 1,
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_OP_WIDTH  = 18,
    parameter int TOTAL_WIDTH    = NUM_DATA*DATA_WIDTH+FUNC_WIDTH,
    parameter int TOTAL_OP_WIDTH = NUM_DATA*DATA_OP_WIDTH+FUNC_WIDTH,
    parameter int EN_SCALE       = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter int X              = 2,
    parameter int Y              = 1,
    parameter int Z              = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clr,
    input  logic                          i_vld,
    input  logic [TOTAL_OP_WIDTH-1:0]     i_data,
    output logic                          o_vld,
    input  logic                          i_rdy,
    output logic [TOTAL_WIDTH-1:0]        o_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_drop,
    output logic [7:0]                    o_drop_cnt,
    output logic                          o_sat
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_PW = DATA_OP_WIDTH + 17;
    localparam int c_HW = DATA_OP_WIDTH - DATA_WIDTH + 1;
    localparam logic signed [c_PW-1:0] c_GAIN = c_PW'(39797);
    localparam logic signed [c_PW-1:0] c_RND  = c_PW'(32768);
    localparam logic [DATA_WIDTH-1:0]  c_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]  c_MIN  = ~c_MAX;

    logic [NUM_DATA-1:0][DATA_OP_WIDTH-1:0] w_s1_next;
    logic [NUM_DATA-1:0][DATA_WIDTH-1:0]    w_s2_next;
    logic [NUM_DATA-1:0]                    w_clamp;

    logic                                   r_s1_vld;
    logic [FUNC_WIDTH-1:0]                  r_s1_func;
    logic [NUM_DATA-1:0][DATA_OP_WIDTH-1:0] r_s1_lane;
    logic                                   r_s2_vld;
    logic [FUNC_WIDTH-1:0]                  r_s2_func;
    logic [NUM_DATA-1:0][DATA_WIDTH-1:0]    r_s2_lane;
    logic                                   r_s2_sat;

    logic [TOTAL_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]        r_wr_ptr;
    logic [c_AW-1:0]        r_rd_ptr;
    logic [c_CW-1:0]        r_count;
    logic                   r_drop;
    logic [7:0]             r_drop_cnt;
    logic                   r_sat;

    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_sat_evt;

    for (genvar n = 0; n < NUM_DATA; n++) begin : g_lane
        logic signed [DATA_OP_WIDTH-1:0] w_in;
        logic [c_HW-1:0]                 w_hi;
        logic                            w_ovf;

        assign w_in = i_data[n*DATA_OP_WIDTH +: DATA_OP_WIDTH];

        if (EN_SCALE != 0 && (n == X || n == Y)) begin : g_scale
            logic signed [c_PW-1:0] w_prod;
            logic signed [c_PW-1:0] w_rnd;
            logic                   w_unused;
            assign w_prod = $signed({{17{w_in[DATA_OP_WIDTH-1]}}, w_in}) * c_GAIN;
            assign w_rnd  = w_prod + c_RND;
            // |v| * 0.607 always fits back in the input lane width
            assign w_s1_next[n] = w_rnd[DATA_OP_WIDTH+15:16];
            assign w_unused     = ^{w_rnd[c_PW-1], w_rnd[15:0]};
        end else begin : g_pass
            assign w_s1_next[n] = w_in;
        end

        assign w_hi         = r_s1_lane[n][DATA_OP_WIDTH-1:DATA_WIDTH-1];
        assign w_ovf        = (w_hi != '0) && (w_hi != '1);
        assign w_clamp[n]   = w_ovf;
        assign w_s2_next[n] = !w_ovf ? r_s1_lane[n][DATA_WIDTH-1:0] :
                              (r_s1_lane[n][DATA_OP_WIDTH-1] ? c_MIN : c_MAX);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s1_vld <= i_vld;
            r_s2_vld <= r_s1_vld;
        end
    end

    always_ff @(posedge i_clk) begin
        r_s1_func <= i_data[TOTAL_OP_WIDTH-1 -: FUNC_WIDTH];
        r_s1_lane <= w_s1_next;
        r_s2_func <= r_s1_func;
        r_s2_lane <= w_s2_next;
        r_s2_sat  <= |w_clamp;
    end

    assign o_vld     = (r_count != '0);
    assign w_pop     = o_vld && i_rdy;
    assign w_push    = r_s2_vld && ((r_count < c_CW'(FIFO_DEPTH)) || w_pop);
    assign w_drop    = r_s2_vld && !w_push;
    assign w_sat_evt = r_s2_vld && r_s2_sat;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_s2_func, r_s2_lane};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    // A clear coinciding with an event restarts the statistics from that event
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (i_clr) begin
                r_drop_cnt <= {7'd0, w_drop};
                r_sat      <= w_sat_evt;
            end else begin
                if (w_drop && (r_drop_cnt != 8'hFF)) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
                r_sat <= r_sat | w_sat_evt;
            end
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty
    assign o_data     = o_vld ? r_mem[r_rd_ptr] : '0;
    assign o_count    = r_count;
    assign o_full     = (r_count == c_CW'(FIFO_DEPTH));
    assign o_drop     = r_drop;
    assign o_drop_cnt = r_drop_cnt;
    assign o_sat      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_cordic_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_result_collector
// Purpose  : Directed self-checking bench for cordic_result_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_result_collector;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_clr;
    logic        i_vld;
    logic [54:0] i_data;
    logic        o_vld;
    logic        i_rdy;
    logic [48:0] o_data;
    logic [2:0]  o_count;
    logic        o_full;
    logic        o_drop;
    logic [7:0]  o_drop_cnt;
    logic        o_sat;

    int n_checks = 0;
    int n_errors = 0;

    cordic_result_collector dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_clr),
        .i_vld      (i_vld),
        .i_data     (i_data),
        .o_vld      (o_vld),
        .i_rdy      (i_rdy),
        .o_data     (o_data),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_drop     (o_drop),
        .o_drop_cnt (o_drop_cnt),
        .o_sat      (o_sat)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        f;
        logic [17:0] x;
        logic [17:0] y;
        logic [17:0] z;
        logic [15:0] ex;
        logic [15:0] ey;
        logic [15:0] ez;
        logic        esat;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [54:0] beat(logic f, logic [17:0] x, logic [17:0] y, logic [17:0] z);
        return {f, x, y, z};
    endfunction

    function automatic logic [48:0] outw(logic f, logic [15:0] x, logic [15:0] y, logic [15:0] z);
        return {f, x, y, z};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int drops;
        // scaled lanes: (v*39797+32768)>>>16 worked by hand; Z passes unscaled
        tbl[0] = '{1'b1, 18'd10000, 18'd10000, 18'd500, 16'h17B9, 16'h17B9, 16'h01F4, 1'b0};
        tbl[1] = '{1'b0, -18'sd10000, 18'd1, -18'sd1, 16'hE847, 16'h0001, 16'hFFFF, 1'b0};
        tbl[2] = '{1'b1, -18'sd1, 18'd0, 18'd32767, 16'hFFFF, 16'h0000, 16'h7FFF, 1'b0};
        tbl[3] = '{1'b0, 18'h1FFFF, 18'd0, 18'd40000, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1};
        tbl[4] = '{1'b1, 18'd0, 18'h20000, -18'sd40000, 16'h0000, 16'h8000, 16'h8000, 1'b1};
        tbl[5] = '{1'b0, 18'd0, 18'd0, -18'sd32768, 16'h0000, 16'h0000, 16'h8000, 1'b0};
        tbl[6] = '{1'b1, 18'd0, 18'd0, 18'd32768, 16'h0000, 16'h0000, 16'h7FFF, 1'b1};
        tbl[7] = '{1'b0, 18'd0, 18'd0, -18'sd32769, 16'h0000, 16'h0000, 16'h8000, 1'b1};

        i_rst_n = 1'b0; i_clr = 1'b0; i_vld = 1'b0; i_rdy = 1'b1; i_data = '0;
        tick(); tick();
        i_rst_n = 1'b1;
        tick();
        chk("reset o_vld", 64'(o_vld), 64'd0);
        chk("reset o_count", 64'(o_count), 64'd0);
        chk("reset o_full", 64'(o_full), 64'd0);
        chk("reset o_drop_cnt", 64'(o_drop_cnt), 64'd0);
        chk("reset o_sat", 64'(o_sat), 64'd0);
        chk("reset o_data", 64'(o_data), 64'd0);

        for (int i = 0; i < 8; i++) begin
            i_clr = 1'b1; tick(); i_clr = 1'b0;
            i_vld = 1'b1; i_data = beat(tbl[i].f, tbl[i].x, tbl[i].y, tbl[i].z);
            tick();
            i_vld = 1'b0;
            tick();
            chk($sformatf("vec%0d early o_vld", i), 64'(o_vld), 64'd0);
            tick();
            chk($sformatf("vec%0d o_vld", i), 64'(o_vld), 64'd1);
            chk($sformatf("vec%0d o_data", i), 64'(o_data),
                64'(outw(tbl[i].f, tbl[i].ex, tbl[i].ey, tbl[i].ez)));
            chk($sformatf("vec%0d o_sat", i), 64'(o_sat), 64'(tbl[i].esat));
            tick();
            chk($sformatf("vec%0d drained", i), 64'(o_count), 64'd0);
        end

        // sticky saturation survives a clean beat, clears only on i_clr
        i_vld = 1'b1; i_data = beat(1'b0, 18'd0, 18'd0, 18'd7);
        tick(); i_vld = 1'b0; tick(); tick(); tick();
        chk("sat sticky", 64'(o_sat), 64'd1);
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        chk("sat cleared", 64'(o_sat), 64'd0);

        // overflow: 6 beats into a stalled FIFO
        i_rdy = 1'b0; drops = 0;
        for (int i = 1; i <= 6; i++) begin
            i_vld = 1'b1; i_data = beat(1'b0, 18'd0, 18'd0, 18'(i));
            tick();
            drops += int'(o_drop);
        end
        i_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            drops += int'(o_drop);
        end
        chk("ovf o_count", 64'(o_count), 64'd4);
        chk("ovf o_full", 64'(o_full), 64'd1);
        chk("ovf o_drop_cnt", 64'(o_drop_cnt), 64'd2);
        chk("ovf drop pulses", 64'(drops), 64'd2);
        i_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf order %0d", i), 64'(o_data), 64'(outw(1'b0, 16'd0, 16'd0, 16'(i))));
            tick();
        end
        chk("ovf empty", 64'(o_count), 64'd0);

        // full FIFO with simultaneous pop and push
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        i_rdy = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            i_vld = 1'b1; i_data = beat(1'b0, 18'd0, 18'd0, 18'(i));
            tick();
        end
        i_vld = 1'b0; tick(); tick();
        chk("pp filled", 64'(o_count), 64'd4);
        i_vld = 1'b1; i_data = beat(1'b0, 18'd0, 18'd0, 18'd14); tick();
        i_data = beat(1'b0, 18'd0, 18'd0, 18'd15); tick();
        i_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_data = beat(1'b0, 18'd0, 18'd0, 18'(16 + i));
            tick();
            chk($sformatf("pp count %0d", i), 64'(o_count), 64'd4);
            chk($sformatf("pp drop %0d", i), 64'(o_drop), 64'd0);
            chk($sformatf("pp head %0d", i), 64'(o_data), 64'(outw(1'b0, 16'd0, 16'd0, 16'(11 + i))));
        end
        i_vld = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("pp drop_cnt", 64'(o_drop_cnt), 64'd0);

        // clear colliding with a saturated, dropped beat
        i_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            i_vld = 1'b1; i_data = beat(1'b0, 18'd0, 18'd0, 18'(20 + i));
            tick();
        end
        i_vld = 1'b0; tick(); tick(); tick();
        chk("clr pre drop_cnt", 64'(o_drop_cnt), 64'd5);
        chk("clr pre o_sat", 64'(o_sat), 64'd0);
        i_vld = 1'b1; i_data = beat(1'b0, 18'd0, 18'd0, 18'd40000);
        tick(); i_vld = 1'b0;
        tick(); i_clr = 1'b1;
        tick(); i_clr = 1'b0;
        chk("clr drop_cnt", 64'(o_drop_cnt), 64'd1);
        chk("clr o_drop", 64'(o_drop), 64'd1);
        chk("clr o_sat", 64'(o_sat), 64'd1);
        i_rdy = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // reset with 3 buffered and 2 in flight
        i_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            i_vld = 1'b1; i_data = beat(1'b1, 18'd0, 18'd0, 18'(30 + i));
            tick();
        end
        i_vld = 1'b0; i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        chk("rst o_vld", 64'(o_vld), 64'd0);
        chk("rst o_count", 64'(o_count), 64'd0);
        chk("rst o_full", 64'(o_full), 64'd0);
        chk("rst o_drop_cnt", 64'(o_drop_cnt), 64'd0);
        chk("rst o_data", 64'(o_data), 64'd0);
        i_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rst flushed vld %0d", i), 64'(o_vld), 64'd0);
            chk($sformatf("rst flushed drop %0d", i), 64'(o_drop), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
